fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the pipelined MIPS core. It owns the PC and issues one request at a time to a variable-latency instruction memory. It delivers `{pc_plus_4, instr}` pairs to the decode stage pipeline register, which captures them when not stalled. It also absorbs branch/jump redirects and discards in-flight fetches that have gone stale.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded at reset; must be word aligned.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_ni`, input, 1: reset; synchronous, active-low.
- `stall_f_i`, input, 1: hazard unit stall. The decode register will not accept the presented instruction this cycle.
- `redirect_i`, input, 1: taken branch/jump this cycle.
- `redirect_pc_i`, input, 32: redirect target; bits [1:0] are ignored (forced to 0).
- `imem_req_o`, output, 1: request valid.
- `imem_addr_o`, output, 32: request word address; equals `pc_f_o`.
- `imem_ready_i`, input, 1: memory accepts the request this cycle.
- `imem_rvalid_i`, input, 1: read data valid; at most one per accepted request, never in the same cycle as acceptance.
- `imem_rdata_i`, input, 32: instruction word.
- `pc_f_o`, output, 32: current fetch PC.
- `pc_plus_4_f_o`, output, 32: `pc_f_o + 4`, modulo 2^32 (`32'hFFFF_FFFC` wraps to `0`).
- `instr_f_o`, output, 32: instruction presented to decode.
- `valid_f_o`, output, 1: `instr_f_o` is valid this cycle.
- `busy_o`, output, 1: equals `~valid_f_o`; the hazard unit flushes decode when set.

## Operation

PC register:
- Holds `RESET_PC` after reset.
- Advances by 4 only on consume: `valid_f_o & ~stall_f_i`.
- On `redirect_i`, loads `{redirect_pc_i[31:2], 2'b00}`.
- A redirect has priority over consume and stall.

Instruction buffer:
- 32-bit register that holds returned data while decode is stalled.

State machine (reset state REQ):
- **REQ**: drive `imem_req_o = 1`.
  - `imem_ready_i & ~redirect_i` → WAIT.
  - `~imem_ready_i & redirect_i` → update PC, stay in REQ (the new address is driven next cycle).
  - `imem_ready_i & redirect_i` → the old address was accepted; update PC → DROP.
- **WAIT**: drive `imem_req_o = 0`.
  - `rvalid & redirect_i` → discard data, update PC → REQ.
  - `rvalid & ~stall_f_i` → present `imem_rdata_i` combinationally (`valid_f_o = 1`), PC += 4 → REQ.
  - `rvalid & stall_f_i` → present and capture the data into the buffer → HOLD.
  - `~rvalid & redirect_i` → update PC → DROP.
- **HOLD**: present the buffer with `valid_f_o = 1`.
  - `redirect_i` → discard the buffer, update PC → REQ.
  - `~stall_f_i` → PC += 4 → REQ.
  - Otherwise stay in HOLD.
- **DROP**: the outstanding response is stale; `valid_f_o = 0`.
  - `rvalid` → discard → REQ.
  - `redirect_i` → update PC, remain in DROP until `rvalid`.

Output rules:
- `valid_f_o` is forced to 0 in any cycle where `redirect_i = 1`.
- When `valid_f_o = 0`, `instr_f_o = 0` (NOP).
- At most one request is outstanding at any time.

## Timing

Reset:
- While `rst_ni = 0`, `imem_req_o`, `valid_f_o` and `instr_f_o` are forced to 0 and `busy_o = 1`.
- After the first edge with `rst_ni = 0`: PC = `RESET_PC`, state = REQ, buffer = 0.
- Reset asserted mid-request abandons it; the memory model must tolerate an unclaimed `rvalid`.

Latency and throughput:
- Minimum latency from request acceptance (cycle N) to `valid_f_o` is N+1, with a one-cycle memory.
- Next request is issued at N+2.
- Peak throughput is one instruction every 2 cycles.
- The stall path adds no cycles beyond the stall itself: HOLD releases in the first cycle with `stall_f_i = 0`.

Combinational paths:
- `pc_plus_4_f_o` and `imem_addr_o` come straight from the PC register.
- `valid_f_o` and `instr_f_o` are combinational from state, `imem_rvalid_i`, `imem_rdata_i` and `redirect_i`.

## Test plan

- **Reset:** hold `rst_ni` low 2 cycles, `RESET_PC = 32'h0000_3000` → `imem_req_o = 0` during reset. First cycle after release: `imem_req_o = 1`, `imem_addr_o = 32'h3000`, `pc_plus_4_f_o = 32'h3004`.
- **Streaming:** one-cycle memory returning `0x20080001`, `0x20090002` with no stalls → each word presented with `valid_f_o = 1` for exactly 1 cycle. PCs run `0x3000`, `0x3004`; requests are issued every 2nd cycle.
- **Stall:** `stall_f_i = 1` for 3 cycles spanning `rvalid` with data `0xDEADBEEF` → `instr_f_o` stays `0xDEADBEEF` and `valid_f_o = 1` for the stall plus 1 cycle. PC advances only after release; no new request while in HOLD.
- **Redirect in flight:** request accepted at `0x3008`; next cycle `redirect_i = 1`, `redirect_pc_i = 32'h0000_4003`; memory returns 3 cycles later → returned word is never presented. Next request address is `0x4000`.
- **Simultaneous events:** `redirect_i`, `imem_ready_i` in REQ together; then in WAIT `redirect_i` with `rvalid` together → both responses are discarded, `valid_f_o = 0`, and the final request uses the latest redirect target.
- **Wrap-around:** redirect to `32'hFFFF_FFFC`, consume that instruction → `pc_plus_4_f_o = 0` and the next request address is `32'h0000_0000`.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch stage with single-outstanding imem requests
// Owns the PC, buffers data across decode stalls and drops responses made stale by redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_f_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus_4_f_o,
  output logic [31:0] instr_f_o,
  output logic        valid_f_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redirect_tgt;
  logic        consume;
  logic        unused_bits;

  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
  assign unused_bits  = &{1'b0, redirect_pc_i[1:0]};

  assign pc_f_o        = pc_q;
  assign imem_addr_o   = pc_q;
  assign pc_plus_4_f_o = pc_q + 32'd4;
  assign imem_req_o    = rst_ni & (state_q == S_REQ);

  // A redirect always squashes whatever would otherwise be presented this cycle.
  always_comb begin
    valid_f_o = 1'b0;
    instr_f_o = 32'h0;
    if (rst_ni && !redirect_i) begin
      if (state_q == S_WAIT && imem_rvalid_i) begin
        valid_f_o = 1'b1;
        instr_f_o = imem_rdata_i;
      end else if (state_q == S_HOLD) begin
        valid_f_o = 1'b1;
        instr_f_o = buf_q;
      end
    end
  end

  assign busy_o  = ~valid_f_o;
  assign consume = valid_f_o & ~stall_f_i;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    if (redirect_i)   pc_d = redirect_tgt;
    else if (consume) pc_d = pc_q + 32'd4;
    else              pc_d = pc_q;

    case (state_q)
      S_REQ: begin
        if (imem_ready_i) state_d = redirect_i ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect_i || !stall_f_i) begin
            state_d = S_REQ;
          end else begin
            buf_d   = imem_rdata_i;
            state_d = S_HOLD;
          end
        end else if (redirect_i) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect_i || !stall_f_i) state_d = S_REQ;
      end
      S_DROP: begin
        // Stale data is never presented; a further redirect only retargets the PC.
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_f_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_f_o;
  logic [31:0] pc_plus_4_f_o;
  logic [31:0] instr_f_o;
  logic        valid_f_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .stall_f_i     (stall_f_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_f_o        (pc_f_o),
    .pc_plus_4_f_o (pc_plus_4_f_o),
    .instr_f_o     (instr_f_o),
    .valid_f_o     (valid_f_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; stall_f_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;

    // Reset
    cyc();
    check("rst_req", {31'h0, imem_req_o}, 32'h0);
    check("rst_valid", {31'h0, valid_f_o}, 32'h0);
    cyc();
    check("rst_req2", {31'h0, imem_req_o}, 32'h0);
    check("rst_instr", instr_f_o, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h1);
    rst_ni = 1'b1; settle();
    check("rel_req", {31'h0, imem_req_o}, 32'h1);
    check("rel_addr", imem_addr_o, 32'h3000);
    check("rel_pc4", pc_plus_4_f_o, 32'h3004);

    // Streaming with a one-cycle memory
    imem_ready_i = 1'b1; settle();
    cyc();
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2008_0001; settle();
    check("s0_valid", {31'h0, valid_f_o}, 32'h1);
    check("s0_instr", instr_f_o, 32'h2008_0001);
    check("s0_req", {31'h0, imem_req_o}, 32'h0);
    check("s0_pc", pc_f_o, 32'h3000);
    cyc();
    imem_rvalid_i = 1'b0; settle();
    check("s1_valid", {31'h0, valid_f_o}, 32'h0);
    check("s1_req", {31'h0, imem_req_o}, 32'h1);
    check("s1_addr", imem_addr_o, 32'h3004);
    imem_ready_i = 1'b1; settle();
    cyc();
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2009_0002; settle();
    check("s2_valid", {31'h0, valid_f_o}, 32'h1);
    check("s2_instr", instr_f_o, 32'h2009_0002);
    check("s2_pc", pc_f_o, 32'h3004);
    cyc();
    imem_rvalid_i = 1'b0; settle();
    check("s3_valid", {31'h0, valid_f_o}, 32'h0);
    check("s3_addr", imem_addr_o, 32'h3008);

    // Redirect while a fetch is in flight
    imem_ready_i = 1'b1; settle();
    cyc();
    imem_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_4003; settle();
    check("r0_valid", {31'h0, valid_f_o}, 32'h0);
    cyc();
    redirect_i = 1'b0; settle();
    check("r1_req", {31'h0, imem_req_o}, 32'h0);
    check("r1_addr", imem_addr_o, 32'h4000);
    cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0; settle();
    check("r2_valid", {31'h0, valid_f_o}, 32'h0);
    check("r2_instr", instr_f_o, 32'h0);
    check("r2_busy", {31'h0, busy_o}, 32'h1);
    cyc();
    imem_rvalid_i = 1'b0; settle();
    check("r3_req", {31'h0, imem_req_o}, 32'h1);
    check("r3_addr", imem_addr_o, 32'h4000);

    // Stall spanning rvalid
    imem_ready_i = 1'b1; stall_f_i = 1'b1; settle();
    cyc();
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; settle();
    check("h0_valid", {31'h0, valid_f_o}, 32'h1);
    check("h0_instr", instr_f_o, 32'hDEAD_BEEF);
    for (int i = 1; i <= 2; i++) begin
      cyc();
      imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; settle();
      check($sformatf("h%0d_valid", i), {31'h0, valid_f_o}, 32'h1);
      check($sformatf("h%0d_instr", i), instr_f_o, 32'hDEAD_BEEF);
      check($sformatf("h%0d_req", i), {31'h0, imem_req_o}, 32'h0);
      check($sformatf("h%0d_pc", i), pc_f_o, 32'h4000);
    end
    cyc();
    stall_f_i = 1'b0; settle();
    check("h3_valid", {31'h0, valid_f_o}, 32'h1);
    check("h3_instr", instr_f_o, 32'hDEAD_BEEF);
    check("h3_pc", pc_f_o, 32'h4000);
    cyc();
    check("h4_valid", {31'h0, valid_f_o}, 32'h0);
    check("h4_req", {31'h0, imem_req_o}, 32'h1);
    check("h4_addr", imem_addr_o, 32'h4004);

    // Simultaneous redirect+ready in REQ, then redirect+rvalid in WAIT
    imem_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_5000; settle();
    check("x0_valid", {31'h0, valid_f_o}, 32'h0);
    cyc();
    imem_ready_i = 1'b0; redirect_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111; settle();
    check("x1_valid", {31'h0, valid_f_o}, 32'h0);
    check("x1_req", {31'h0, imem_req_o}, 32'h0);
    cyc();
    imem_rvalid_i = 1'b0; settle();
    check("x2_addr", imem_addr_o, 32'h5000);
    imem_ready_i = 1'b1; settle();
    cyc();
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_6004; settle();
    check("x3_valid", {31'h0, valid_f_o}, 32'h0);
    check("x3_instr", instr_f_o, 32'h0);
    cyc();
    imem_rvalid_i = 1'b0; redirect_i = 1'b0; settle();
    check("x4_req", {31'h0, imem_req_o}, 32'h1);
    check("x4_addr", imem_addr_o, 32'h6004);

    // Wrap-around; low target bits are ignored
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; settle();
    cyc();
    redirect_i = 1'b0; settle();
    check("w0_addr", imem_addr_o, 32'hFFFF_FFFC);
    check("w0_pc4", pc_plus_4_f_o, 32'h0);
    imem_ready_i = 1'b1; settle();
    cyc();
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_1234; settle();
    check("w1_instr", instr_f_o, 32'h0000_1234);
    cyc();
    imem_rvalid_i = 1'b0; settle();
    check("w2_addr", imem_addr_o, 32'h0);
    check("w2_pc4", pc_plus_4_f_o, 32'h4);

    // Reset mid-request abandons it
    imem_ready_i = 1'b1; settle();
    cyc();
    imem_ready_i = 1'b0; rst_ni = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_3333; settle();
    check("m0_valid", {31'h0, valid_f_o}, 32'h0);
    check("m0_instr", instr_f_o, 32'h0);
    cyc();
    rst_ni = 1'b1; imem_rvalid_i = 1'b0; settle();
    check("m1_req", {31'h0, imem_req_o}, 32'h1);
    check("m1_addr", imem_addr_o, 32'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
